// File: rtl/matrix_rf_rw_port.sv
// rtl/matrix_rf_rw_port.sv - matrix register file responder for one row-streaming read port and one write port
// Optional burst sequence checker is compiled in when MATRIX_RF_SEQ_CHECK_EN is defined.
module matrix_rf_rw_port #(
    parameter int MESH_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 8,
    localparam int RLEN      = DATA_WIDTH * MESH_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [$clog2(N_REGS)-1:0]     raddr_i,
    input  logic [$clog2(MESH_WIDTH)-1:0] rrowaddr_i,
    output logic [RLEN-1:0]               rdata_o,
    output logic                          rdata_valid_o,
    input  logic                          rdata_ready_i,
    input  logic                          rlast_i,
    input  logic [$clog2(N_REGS)-1:0]     waddr_i,
    input  logic [$clog2(MESH_WIDTH)-1:0] wrowaddr_i,
    input  logic [RLEN-1:0]               wdata_i,
    input  logic                          we_i,
    input  logic                          wlast_i,
    output logic                          wready_o,
    output logic [N_REGS-1:0]             reg_busy_o,
    output logic                          protocol_err_o
);
    localparam int AW = $clog2(N_REGS);
    localparam int RW = $clog2(MESH_WIDTH);

    logic [RLEN-1:0] mem_q [N_REGS][MESH_WIDTH];
    logic            rd_act_q, wr_act_q;
    logic [AW-1:0]   rd_reg_q, wr_reg_q;
    logic            rd_hs, wr_hs;

    assign rdata_o       = mem_q[raddr_i][rrowaddr_i];
    assign rdata_valid_o = ~(wr_act_q & (wr_reg_q == raddr_i));
    assign rd_hs         = rdata_valid_o & rdata_ready_i;

    // A same-cycle read handshake on the write's register wins, so the two locks can never cross.
    assign wready_o = ~((rd_act_q & (rd_reg_q == waddr_i)) | (rd_hs & (raddr_i == waddr_i)));
    assign wr_hs    = we_i & wready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < N_REGS; r++) begin
                for (int c = 0; c < MESH_WIDTH; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_hs) begin
            mem_q[waddr_i][wrowaddr_i] <= wdata_i;
        end
    end

    // Single-beat bursts take the last-beat branch and never latch a lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_act_q <= 1'b0;
            rd_reg_q <= '0;
            wr_act_q <= 1'b0;
            wr_reg_q <= '0;
        end else begin
            if (rd_hs && rlast_i) begin
                rd_act_q <= 1'b0;
            end else if (rd_hs && !rd_act_q) begin
                rd_act_q <= 1'b1;
                rd_reg_q <= raddr_i;
            end
            if (wr_hs && wlast_i) begin
                wr_act_q <= 1'b0;
            end else if (wr_hs && !wr_act_q) begin
                wr_act_q <= 1'b1;
                wr_reg_q <= waddr_i;
            end
        end
    end

    always_comb begin
        reg_busy_o = '0;
        if (rd_act_q) reg_busy_o[rd_reg_q] = 1'b1;
        if (wr_act_q) reg_busy_o[wr_reg_q] = 1'b1;
    end

`ifdef MATRIX_RF_SEQ_CHECK_EN
    logic [RW-1:0] rd_exp_q, wr_exp_q;
    logic          err_q;
    logic          rd_err, wr_err;

    assign rd_err = rd_hs & ((rrowaddr_i != rd_exp_q)
                           | (rd_act_q & (raddr_i != rd_reg_q))
                           | (rlast_i & (rrowaddr_i != RW'(MESH_WIDTH - 1))));
    assign wr_err = wr_hs & ((wrowaddr_i != wr_exp_q)
                           | (wr_act_q & (waddr_i != wr_reg_q))
                           | (wlast_i & (wrowaddr_i != RW'(MESH_WIDTH - 1))));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_exp_q <= '0;
            wr_exp_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (rd_hs) rd_exp_q <= rlast_i ? '0 : rd_exp_q + RW'(1);
            if (wr_hs) wr_exp_q <= wlast_i ? '0 : wr_exp_q + RW'(1);
            err_q <= err_q | rd_err | wr_err;
        end
    end

    assign protocol_err_o = err_q;
`else
    assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_rf_rw_port.sv
// tb/tb_matrix_rf_rw_port.sv - scoreboard bench for matrix_rf_rw_port with a behavioural register-file model
module tb_matrix_rf_rw_port;
    localparam int MESH = 4;
    localparam int DW   = 32;
    localparam int NR   = 8;
    localparam int RLEN = DW * MESH;
    localparam int AW   = $clog2(NR);
    localparam int RW   = $clog2(MESH);

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [AW-1:0]   raddr = '0, waddr = '0;
    logic [RW-1:0]   rrow = '0, wrow = '0;
    logic            rdy = 1'b0, rlast = 1'b0, we = 1'b0, wlast = 1'b0;
    logic [RLEN-1:0] wdata = '0;
    logic [RLEN-1:0] rdata;
    logic            rvalid, wready, perr;
    logic [NR-1:0]   busy;

    matrix_rf_rw_port #(.MESH_WIDTH(MESH), .DATA_WIDTH(DW), .N_REGS(NR)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .raddr_i(raddr), .rrowaddr_i(rrow), .rdata_o(rdata), .rdata_valid_o(rvalid),
        .rdata_ready_i(rdy), .rlast_i(rlast),
        .waddr_i(waddr), .wrowaddr_i(wrow), .wdata_i(wdata), .we_i(we), .wlast_i(wlast),
        .wready_o(wready), .reg_busy_o(busy), .protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RLEN-1:0] rdata;
        logic            valid;
        logic            wready;
        logic [NR-1:0]   busy;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents plus which register (or -1) each port holds locked.
    logic [RLEN-1:0] m_mem [NR][MESH];
    int              rd_lock, wr_lock, rd_exp, wr_exp;
    bit              m_err;
    bit              last_rh, last_wh;

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < MESH; c++) m_mem[r][c] = '0;
        rd_lock = -1; wr_lock = -1; rd_exp = 0; wr_exp = 0; m_err = 0;
    endtask

    task automatic tick(output bit rh, output bit wh);
        exp_t e;
        bit   v, wr, rhs, whs;
        if (!rst_ni) model_reset();
        v   = !(wr_lock == int'(raddr));
        rhs = v && rdy;
        wr  = !((rd_lock == int'(waddr)) || (rhs && raddr == waddr));
        whs = we && wr;
        e.rdata  = m_mem[raddr][rrow];
        e.valid  = v;
        e.wready = wr;
        e.busy   = '0;
        if (rd_lock >= 0) e.busy[rd_lock] = 1'b1;
        if (wr_lock >= 0) e.busy[wr_lock] = 1'b1;
        e.err = m_err;
        sb.push_back(e);
        rh = 0; wh = 0;
        if (rst_ni) begin
`ifdef MATRIX_RF_SEQ_CHECK_EN
            if (rhs) begin
                if (int'(rrow) != rd_exp || (rd_lock >= 0 && int'(raddr) != rd_lock) ||
                    (rlast && int'(rrow) != MESH - 1)) m_err = 1;
                rd_exp = rlast ? 0 : (rd_exp + 1) % MESH;
            end
            if (whs) begin
                if (int'(wrow) != wr_exp || (wr_lock >= 0 && int'(waddr) != wr_lock) ||
                    (wlast && int'(wrow) != MESH - 1)) m_err = 1;
                wr_exp = wlast ? 0 : (wr_exp + 1) % MESH;
            end
`endif
            if (whs) m_mem[waddr][wrow] = wdata;
            if (rhs) begin
                if (rlast) rd_lock = -1;
                else if (rd_lock < 0) rd_lock = int'(raddr);
            end
            if (whs) begin
                if (wlast) wr_lock = -1;
                else if (wr_lock < 0) wr_lock = int'(waddr);
            end
            rh = rhs; wh = whs;
        end
        @(posedge clk); #1;
    endtask

    task automatic step();
        tick(last_rh, last_wh);
    endtask

    task automatic set_rd(bit r, int a, int row, bit l);
        rdy = r; raddr = AW'(a); rrow = RW'(row); rlast = l;
    endtask

    task automatic set_wr(bit w, int a, int row, logic [RLEN-1:0] d, bit l);
        we = w; waddr = AW'(a); wrow = RW'(row); wdata = d; wlast = l;
    endtask

    function automatic logic [RLEN-1:0] rnd_row();
        logic [RLEN-1:0] r;
        for (int i = 0; i < RLEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(string name, logic [RLEN-1:0] act, logic [RLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("rdata_valid", RLEN'(rvalid), RLEN'(e.valid));
                chk("wready", RLEN'(wready), RLEN'(e.wready));
                chk("reg_busy", RLEN'(busy), RLEN'(e.busy));
                chk("protocol_err", RLEN'(perr), RLEN'(e.err));
            end
        end
    end

    initial begin
        bit rb_act, rb_one, wb_act, wb_one;
        int rb_reg, rb_row, wb_reg, wb_row;
        model_reset();
        @(posedge clk); #1;
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        for (int r = 0; r < MESH; r++) begin
            set_rd(1, 3, r, r == MESH - 1); step();
        end
        set_rd(0, 3, 0, 0); step();

        for (int r = 0; r < MESH; r++) begin
            set_wr(1, 2, r, RLEN'(32'hA0 + r), r == MESH - 1); step();
        end
        set_wr(0, 2, 0, '0, 0);
        for (int r = 0; r < MESH; r++) begin
            set_rd(1, 2, r, r == MESH - 1); step();
        end
        set_rd(0, 2, 0, 0);

        set_wr(1, 5, 0, rnd_row(), 0); step();
        for (int r = 1; r < MESH; r++) begin
            set_wr(1, 5, r, rnd_row(), r == MESH - 1);
            if (r == 2) set_rd(1, 4, 0, 1); else set_rd(1, 5, 0, 0);
            step();
        end
        set_wr(0, 5, 0, '0, 0);
        for (int r = 0; r < MESH; r++) begin
            set_rd(1, 5, r, r == MESH - 1); step();
        end
        set_rd(0, 5, 0, 0);

        set_rd(1, 1, 0, 0); step();
        for (int r = 1; r < MESH; r++) begin
            set_rd(1, 1, r, r == MESH - 1);
            set_wr(1, 1, 0, RLEN'(32'h55), 0);
            step();
        end
        set_rd(0, 1, 0, 0); step();
        for (int r = 1; r < MESH; r++) begin
            set_wr(1, 1, r, RLEN'(32'h55 + r), r == MESH - 1); step();
        end
        set_wr(0, 1, 0, '0, 0);
        for (int r = 0; r < MESH; r++) begin
            set_rd(1, 1, r, r == MESH - 1); step();
        end

        set_rd(1, 6, 0, 1); set_wr(1, 6, 0, RLEN'(32'h66), 1); step();
        set_rd(0, 6, 0, 0); step();
        set_rd(1, 6, 0, 1); set_wr(1, 7, 0, RLEN'(32'h77), 1); step();
        set_rd(0, 7, 0, 0); set_wr(0, 7, 0, '0, 0); step();

        set_wr(1, 0, 0, rnd_row(), 0); step();
        set_wr(1, 0, 2, rnd_row(), 0); step();
        set_wr(1, 0, 3, rnd_row(), 1); step();
        set_wr(0, 0, 0, '0, 0);
        repeat (3) step();

        rb_act = 0; wb_act = 0; rb_one = 0; wb_one = 0;
        rb_reg = 0; rb_row = 0; wb_reg = 0; wb_row = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_ni = !(cyc == 300 || cyc == 301);
            if (!rst_ni) begin
                rb_act = 0; wb_act = 0;
            end
            if (rst_ni && !rb_act && $urandom_range(0, 3) == 0) begin
                rb_act = 1; rb_reg = $urandom_range(0, NR - 1); rb_row = 0;
                rb_one = ($urandom_range(0, 7) == 0);
            end
            if (rst_ni && !wb_act && $urandom_range(0, 3) == 0) begin
                wb_act = 1; wb_reg = $urandom_range(0, NR - 1); wb_row = 0;
                wb_one = ($urandom_range(0, 7) == 0);
            end
            if (rb_act)
                set_rd($urandom_range(0, 3) != 0, rb_reg,
                       ($urandom_range(0, 31) == 0) ? rb_row ^ 1 : rb_row,
                       rb_one || rb_row == MESH - 1);
            else
                set_rd(0, $urandom_range(0, NR - 1), $urandom_range(0, MESH - 1), 0);
            if (wb_act)
                set_wr($urandom_range(0, 3) != 0, wb_reg, wb_row, rnd_row(),
                       wb_one || wb_row == MESH - 1);
            else
                set_wr(0, $urandom_range(0, NR - 1), $urandom_range(0, MESH - 1), rnd_row(), 0);
            step();
            if (last_rh) begin
                if (rlast) rb_act = 0; else rb_row++;
            end
            if (last_wh) begin
                if (wlast) wb_act = 0; else wb_row++;
            end
        end
        set_rd(0, 0, 0, 0); set_wr(0, 0, 0, '0, 0);
        step();

        @(negedge clk); #1;
        chk("scoreboard_drained", RLEN'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
